// File: rtl/rx_pkg.sv
// Shared receive-side definitions for the lane deserializer and the un-striping stage.
//   COMMA          : K28.5 alignment symbol
//   LOCK_COUNT_DEF : default number of consecutive aligned commas needed to lock
//   state_t        : deserializer FSM states
package rx_pkg;

    localparam logic [7:0]  COMMA          = 8'hBC;
    localparam int unsigned LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/comparador_coma.sv
// Combinational comma detector.
//   dato    in  8  candidate byte
//   es_coma out 1  high when dato equals the comma symbol
module comparador_coma
    import rx_pkg::*;
(
    input  logic [7:0] dato,
    output logic       es_coma
);

    assign es_coma = (dato == COMMA);

endmodule

// File: rtl/serie_paralelo_rx.sv
// Per-lane serial-to-parallel receiver with comma alignment.
// Slides a bit-level window over the stream looking for the comma, confirms
// LOCK_COUNT consecutive byte-aligned commas, then emits one byte every 8
// enabled cycles.
//   clk     in  1  bit clock, rising edge
//   reset   in  1  synchronous active-high reset (priority over enb)
//   enb     in  1  enable; 0 freezes all state and suppresses valid
//   entrada in  1  serial bit, MSB of each byte first
//   salida  out 8  recovered byte
//   valid   out 1  one-cycle strobe, salida updated this cycle
//   activo  out 1  high while locked
module serie_paralelo_rx
    import rx_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       entrada,
    output logic [7:0] salida,
    output logic       valid,
    output logic       activo
);

    // Value bc holds when the next aligned comma completes the lock.
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] bc_q, bc_d;
    logic [7:0] salida_q, salida_d;
    logic       valid_q, valid_d;
    logic       activo_q, activo_d;

    logic [7:0] nsr;
    logic       es_coma;
    logic       fin_byte;

    assign nsr      = {sr_q[6:0], entrada};
    assign fin_byte = (cnt_q == 3'd7);

    comparador_coma u_comparador_coma (
        .dato    (nsr),
        .es_coma (es_coma)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEARCH;
            sr_q     <= 8'h00;
            cnt_q    <= 3'd0;
            bc_q     <= 4'd0;
            salida_q <= 8'h00;
            valid_q  <= 1'b0;
            activo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            bc_q     <= bc_d;
            salida_q <= salida_d;
            valid_q  <= valid_d;
            activo_q <= activo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (enb) begin
            unique case (state_q)
                SEARCH: begin
                    if (es_coma) begin
                        state_d = (LOCK_LAST == 4'd0) ? ACTIVE : ALIGN;
                    end
                end
                ALIGN: begin
                    if (fin_byte) begin
                        if (!es_coma) begin
                            state_d = SEARCH;
                        end else if (bc_q == LOCK_LAST) begin
                            state_d = ACTIVE;
                        end
                    end
                end
                ACTIVE:  state_d = ACTIVE;
                default: state_d = SEARCH;
            endcase
        end
    end

    // Counters and output next values.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        bc_d     = bc_q;
        salida_d = salida_q;
        valid_d  = 1'b0;
        if (enb) begin
            sr_d = nsr;
            unique case (state_q)
                SEARCH: begin
                    // A hit here is the first comma; byte phase starts now.
                    cnt_d = 3'd0;
                    if (es_coma) begin
                        bc_d = (LOCK_LAST == 4'd0) ? 4'd0 : 4'd1;
                    end
                end
                ALIGN: begin
                    cnt_d = cnt_q + 3'd1;
                    if (fin_byte) begin
                        if (!es_coma || bc_q == LOCK_LAST) begin
                            bc_d = 4'd0;
                        end else begin
                            bc_d = bc_q + 4'd1;
                        end
                    end
                end
                ACTIVE: begin
                    cnt_d = cnt_q + 3'd1;
                    if (fin_byte) begin
                        salida_d = nsr;
                        valid_d  = 1'b1;
                    end
                end
                default: begin
                    cnt_d = 3'd0;
                    bc_d  = 4'd0;
                end
            endcase
        end
    end

    assign activo_d = (state_d == ACTIVE);

    assign salida = salida_q;
    assign valid  = valid_q;
    assign activo = activo_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
module tb_serie_paralelo_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic       entrada;
    logic [7:0] salida, salida1;
    logic       valid, valid1;
    logic       activo, activo1;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    serie_paralelo_rx #(.LOCK_COUNT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .entrada (entrada),
        .salida  (salida),
        .valid   (valid),
        .activo  (activo)
    );

    serie_paralelo_rx #(.LOCK_COUNT(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .entrada (entrada),
        .salida  (salida1),
        .valid   (valid1),
        .activo  (activo1)
    );

    // Stream record: optional left-justified prefix bits, then up to 8 bytes
    // left-justified in data (first byte in bits 63:56), sent MSB first.
    typedef struct {
        int          npre;
        logic [7:0]  pre;
        int          nbytes;
        logic [63:0] data;
        int          lock_bit;  // bit count after which activo must be high
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic b, input logic en);
        entrada = b;
        enb     = en;
        @(posedge clk);
        #1;
    endtask

    // Reset is applied with enb low to show reset wins over enable.
    task automatic pulse_reset();
        reset   = 1'b1;
        enb     = 1'b0;
        entrada = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        enb   = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ev, input string nm);
        for (int i = 0; i < 8; i++) begin
            tick(b[7-i], 1'b1);
            chk({nm, " valid"}, {7'd0, valid}, {7'd0, (i == 7) && ev});
        end
        if (ev) chk({nm, " salida"}, salida, b);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   total;
        int   k;
        logic b;
        logic ev;
        total = v.npre + 8 * v.nbytes;
        for (int n = 1; n <= total; n++) begin
            if (n <= v.npre) b = v.pre[8-n];
            else             b = v.data[63-(n-1-v.npre)];
            tick(b, 1'b1);
            ev = (n > v.lock_bit) && (((n - v.lock_bit) % 8) == 0);
            chk($sformatf("vec%0d bit%0d activo", idx, n), {7'd0, activo},
                {7'd0, n >= v.lock_bit});
            chk($sformatf("vec%0d bit%0d valid", idx, n), {7'd0, valid}, {7'd0, ev});
            if (ev) begin
                k = (n - v.npre) / 8 - 1;
                chk($sformatf("vec%0d bit%0d salida", idx, n), salida, v.data[63-8*k -: 8]);
            end
        end
    endtask

    initial begin
        vecs[0] = '{npre: 0, pre: 8'h00, nbytes: 6, data: 64'hBCBC_BCBC_1122_0000,
                    lock_bit: 32};
        vecs[1] = '{npre: 3, pre: 8'hA0, nbytes: 5, data: 64'hBCBC_BCBC_A500_0000,
                    lock_bit: 35};
        vecs[2] = '{npre: 0, pre: 8'h00, nbytes: 8, data: 64'hBCBC_00BC_BCBC_BC5A,
                    lock_bit: 56};

        reset   = 1'b1;
        enb     = 1'b1;
        entrada = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset salida", salida, 8'h00);
        chk("reset valid", {7'd0, valid}, 8'd0);
        chk("reset activo", {7'd0, activo}, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            pulse_reset();
            run_vec(vecs[i], i);
        end

        // Enable gap mid-byte while locked.
        pulse_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC, 1'b0, "gap comma");
        chk("gap locked", {7'd0, activo}, 8'd1);
        send_byte(8'h11, 1'b1, "gap pre");
        for (int i = 0; i < 3; i++) begin
            tick(1'b1 ^ (i == 2), 1'b1);  // C3 = 1100_0011
            chk("gap head valid", {7'd0, valid}, 8'd0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(i[0], 1'b0);
            chk("gap idle valid", {7'd0, valid}, 8'd0);
            chk("gap idle salida", salida, 8'h11);
            chk("gap idle activo", {7'd0, activo}, 8'd1);
        end
        for (int i = 0; i < 5; i++) begin
            tick((i >= 3), 1'b1);
            chk("gap tail valid", {7'd0, valid}, {7'd0, i == 4});
        end
        chk("gap byte", salida, 8'hC3);
        send_byte(8'h7E, 1'b1, "gap post");

        // Reset from the locked state clears every output.
        pulse_reset();
        chk("rst salida", salida, 8'h00);
        chk("rst valid", {7'd0, valid}, 8'd0);
        chk("rst activo", {7'd0, activo}, 8'd0);

        // Reset after the third comma discards the partial lock.
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, "midlock comma");
        pulse_reset();
        chk("midlock activo", {7'd0, activo}, 8'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, "relock comma");
        chk("relock not yet", {7'd0, activo}, 8'd0);
        send_byte(8'hBC, 1'b0, "relock comma4");
        chk("relock activo", {7'd0, activo}, 8'd1);
        send_byte(8'h5A, 1'b1, "relock data");

        // Single-comma lock instance.
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            tick(8'hBC >> (7 - i), 1'b1);
            chk("lc1 activo", {7'd0, activo1}, {7'd0, i == 7});
        end
        for (int i = 0; i < 8; i++) begin
            tick(8'h3C >> (7 - i), 1'b1);
            chk("lc1 valid", {7'd0, valid1}, {7'd0, i == 7});
        end
        chk("lc1 salida", salida1, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
